// File: rtl/axis_dvp.sv
`default_nettype none
// ============================================================================
//  Module      : axis_dvp
//  Description : Converts an AXI4-Stream pixel stream into a DVP-style raster
//                (vsync pulse, vertical blank, hsync-qualified lines with
//                horizontal blank). The raster timing is free-running once a
//                frame starts; input pixels that are missing in their slot
//                are replaced by zero and flagged as an underflow.
//                Optional tlast checking is compiled in when the macro
//                AXIS_DVP_TLAST_CHECK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_dvp #(
    parameter int WIDTH_P   = 8,
    parameter int LINE_W_P  = 640,
    parameter int FRAME_H_P = 480,
    parameter int VSYNC_P   = 8,
    parameter int VBLANK_P  = 16,
    parameter int HBLANK_P  = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [WIDTH_P-1:0] tdata_i,
    input  logic               tvalid_i,
    input  logic               tlast_i,
    output logic               tready_o,
    output logic               vsync_o,
    output logic               hsync_o,
    output logic [WIDTH_P-1:0] data_o,
    output logic               underflow_o,
    output logic               tlast_err_o
);

    // ------------------------------------------------------------------------
    // Counter widths: $clog2 of each bound, never narrower than one bit.
    // ------------------------------------------------------------------------
    localparam int c_X_W = (LINE_W_P > 1) ? $clog2(LINE_W_P) : 1;
    localparam int c_L_W = (FRAME_H_P > 1) ? $clog2(FRAME_H_P) : 1;
    localparam int c_BLANK_MAX =
        (VSYNC_P > VBLANK_P) ? ((VSYNC_P > HBLANK_P) ? VSYNC_P : HBLANK_P)
                             : ((VBLANK_P > HBLANK_P) ? VBLANK_P : HBLANK_P);
    localparam int c_B_W = (c_BLANK_MAX > 1) ? $clog2(c_BLANK_MAX) : 1;

    // Terminal counts: each phase ends on the cycle its counter hits these.
    localparam logic [c_X_W-1:0] c_X_LAST      = c_X_W'(LINE_W_P - 1);
    localparam logic [c_L_W-1:0] c_LINE_LAST   = c_L_W'(FRAME_H_P - 1);
    localparam logic [c_B_W-1:0] c_VSYNC_LAST  = c_B_W'(VSYNC_P - 1);
    localparam logic [c_B_W-1:0] c_VBLANK_LAST = c_B_W'(VBLANK_P - 1);
    localparam logic [c_B_W-1:0] c_HBLANK_LAST = c_B_W'(HBLANK_P - 1);

    // ------------------------------------------------------------------------
    // Raster state encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_VSYNC  = 3'd1;
    localparam logic [2:0] c_ST_VBLANK = 3'd2;
    localparam logic [2:0] c_ST_LINE   = 3'd3;
    localparam logic [2:0] c_ST_HBLANK = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_X_W-1:0]   r_x_cnt;
    logic [c_L_W-1:0]   r_line_cnt;
    logic [c_B_W-1:0]   r_blank_cnt;

    logic               w_in_line;
    logic               w_in_blank;
    logic               w_state_change;
    logic               w_accept;
    logic               w_vsync_d;
    logic               w_hsync_d;
    logic [WIDTH_P-1:0] w_data_d;
    logic               w_underflow_set;

    logic               r_vsync;
    logic               r_hsync;
    logic [WIDTH_P-1:0] r_data;
    logic               r_underflow;

    assign w_in_line      = (r_state == c_ST_LINE);
    assign w_in_blank     = (r_state == c_ST_VSYNC) || (r_state == c_ST_VBLANK) ||
                            (r_state == c_ST_HBLANK);
    assign w_state_change = (w_state_next != r_state);

    // State register: IDLE on reset, otherwise follow the next-state logic.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: each timed phase exits on its terminal count.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (en_i) begin
                    w_state_next = c_ST_VSYNC;
                end
            end
            c_ST_VSYNC: begin
                if (r_blank_cnt == c_VSYNC_LAST) begin
                    w_state_next = c_ST_VBLANK;
                end
            end
            c_ST_VBLANK: begin
                if (r_blank_cnt == c_VBLANK_LAST) begin
                    w_state_next = c_ST_LINE;
                end
            end
            c_ST_LINE: begin
                if (r_x_cnt == c_X_LAST) begin
                    w_state_next = c_ST_HBLANK;
                end
            end
            c_ST_HBLANK: begin
                if (r_blank_cnt == c_HBLANK_LAST) begin
                    // The line counter holds the index of the line just sent.
                    w_state_next = (r_line_cnt == c_LINE_LAST) ? c_ST_IDLE : c_ST_LINE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Phase counters: x and blank counters restart on every state entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_x_cnt     <= '0;
            r_blank_cnt <= '0;
        end else if (w_state_change) begin
            r_x_cnt     <= '0;
            r_blank_cnt <= '0;
        end else begin
            if (w_in_line) begin
                r_x_cnt <= r_x_cnt + c_X_W'(1);
            end
            if (w_in_blank) begin
                r_blank_cnt <= r_blank_cnt + c_B_W'(1);
            end
        end
    end

    // Line index: cleared at frame start, advanced on each HBLANK->LINE hop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_line_cnt <= '0;
        end else if ((r_state == c_ST_IDLE) && (w_state_next == c_ST_VSYNC)) begin
            r_line_cnt <= '0;
        end else if ((r_state == c_ST_HBLANK) && (w_state_next == c_ST_LINE)) begin
            r_line_cnt <= r_line_cnt + c_L_W'(1);
        end
    end

    // Output decode: ready only during LINE; next-cycle DVP values from state.
    always_comb begin
        tready_o        = w_in_line;
        w_accept        = w_in_line && tvalid_i;
        w_vsync_d       = (r_state == c_ST_VSYNC);
        w_hsync_d       = w_in_line;
        w_data_d        = w_accept ? tdata_i : '0;
        w_underflow_set = w_in_line && !tvalid_i;
    end

    // DVP output registers plus the sticky underflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vsync     <= 1'b0;
            r_hsync     <= 1'b0;
            r_data      <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_vsync <= w_vsync_d;
            r_hsync <= w_hsync_d;
            r_data  <= w_data_d;
            if (w_underflow_set) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign vsync_o     = r_vsync;
    assign hsync_o     = r_hsync;
    assign data_o      = r_data;
    assign underflow_o = r_underflow;

`ifdef AXIS_DVP_TLAST_CHECK_EN
    logic r_tlast_err;
    logic w_tlast_err_set;

    // A beat's tlast must mark exactly the last pixel slot of the line.
    assign w_tlast_err_set = w_accept && (tlast_i != (r_x_cnt == c_X_LAST));

    // Sticky tlast error flag; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tlast_err <= 1'b0;
        end else if (w_tlast_err_set) begin
            r_tlast_err <= 1'b1;
        end
    end

    assign tlast_err_o = r_tlast_err;
`else
    // tlast carries no meaning to the raster when checking is compiled out.
    logic w_unused_tlast;
    assign w_unused_tlast = tlast_i;
    assign tlast_err_o    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_dvp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_dvp
//  Description : Scoreboard bench for axis_dvp. Each test pushes the AXIS
//                beats it offers and the per-cycle DVP response it expects;
//                a monitor pops one expectation per cycle and compares it.
//                Honours AXIS_DVP_TLAST_CHECK_EN for the tlast flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_dvp;

    localparam int LW = 4;
    localparam int FH = 2;
    localparam int VS = 3;
    localparam int VB = 2;
    localparam int HB = 2;
    // Cycles from the edge that samples en_i to the next IDLE en_i sample.
    localparam int FRAME_LEN = VS + VB + FH * (LW + HB) + 1;

`ifdef AXIS_DVP_TLAST_CHECK_EN
    localparam bit TE_CHECK = 1'b1;
`else
    localparam bit TE_CHECK = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       en     = 1'b0;
    logic [7:0] tdata  = 8'h00;
    logic       tvalid = 1'b0;
    logic       tlast  = 1'b0;
    logic       tready;
    logic       vsync;
    logic       hsync;
    logic [7:0] data;
    logic       underflow;
    logic       tlast_err;

    always #5 clk = ~clk;

    axis_dvp #(
        .WIDTH_P   (8),
        .LINE_W_P  (LW),
        .FRAME_H_P (FH),
        .VSYNC_P   (VS),
        .VBLANK_P  (VB),
        .HBLANK_P  (HB)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .tdata_i     (tdata),
        .tvalid_i    (tvalid),
        .tlast_i     (tlast),
        .tready_o    (tready),
        .vsync_o     (vsync),
        .hsync_o     (hsync),
        .data_o      (data),
        .underflow_o (underflow),
        .tlast_err_o (tlast_err)
    );

    typedef struct packed {
        logic       v;
        logic       h;
        logic       r;
        logic       uf;
        logic       te;
        logic [7:0] d;
    } exp_t;

    typedef struct packed {
        logic       skip;
        logic       last;
        logic [7:0] d;
    } beat_t;

    exp_t  exp_q[$];
    beat_t beat_q[$];
    int    pass_cnt  = 0;
    int    total_cnt = 0;
    int    chk_idx   = 0;
    logic  m_uf      = 1'b0;
    logic  m_te      = 1'b0;

    // Monitor: one expected output vector per cycle while any are pending.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = '{v: vsync, h: hsync, r: tready, uf: underflow, te: tlast_err, d: data};
            total_cnt++;
            if (got === e) begin
                pass_cnt++;
            end else begin
                $display("FAIL trace[%0d] got v=%b h=%b rdy=%b uf=%b te=%b d=%02h, required v=%b h=%b rdy=%b uf=%b te=%b d=%02h",
                         chk_idx, got.v, got.h, got.r, got.uf, got.te, got.d,
                         e.v, e.h, e.r, e.uf, e.te, e.d);
            end
            chk_idx++;
        end
    end

    // AXIS driver: offers the head beat every cycle; it leaves when tready is seen.
    always @(negedge clk) begin
        if (beat_q.size() > 0) begin
            tvalid = !beat_q[0].skip;
            tdata  = beat_q[0].d;
            tlast  = beat_q[0].last;
            if (tready) begin
                void'(beat_q.pop_front());
            end
        end else begin
            tvalid = 1'b0;
            tdata  = 8'h00;
            tlast  = 1'b0;
        end
    end

    // Pixel slot occupied at frame-relative cycle k, or -1 outside LINE.
    function automatic int slot_at(input int k);
        int t;
        if (k < VS + VB) return -1;
        t = k - (VS + VB);
        if (t >= FH * (LW + HB)) return -1;
        if ((t % (LW + HB)) >= LW) return -1;
        return (t / (LW + HB)) * LW + (t % (LW + HB));
    endfunction

    // Queue the beats and the first n expected cycles of one frame.
    task automatic push_frame(input logic [63:0] px, input logic [7:0] last_mask,
                              input int uf_slot, input int te_slot, input int n);
        for (int j = 0; j < FH * LW; j++) begin
            beat_q.push_back('{skip: (j == uf_slot), last: last_mask[j], d: px[8*j +: 8]});
        end
        for (int k = 0; k < n; k++) begin
            exp_t e;
            int   sp;
            sp   = (k > 0) ? slot_at(k - 1) : -1;
            e.v  = (k >= 1) && (k <= VS);
            e.h  = (sp >= 0);
            e.r  = (slot_at(k) >= 0);
            e.d  = ((sp >= 0) && (sp != uf_slot)) ? px[8*sp +: 8] : 8'h00;
            if ((sp >= 0) && (sp == uf_slot)) m_uf = 1'b1;
            if (TE_CHECK && (sp >= 0) && (sp == te_slot)) m_te = 1'b1;
            e.uf = m_uf;
            e.te = m_te;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{v: 1'b0, h: 1'b0, r: 1'b0, uf: m_uf, te: m_te, d: 8'h00});
        end
    endtask

    // Wait (bounded) until every queued expectation has been checked.
    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0) && (n < 500)) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            total_cnt++;
            $display("FAIL drain_timeout got %0d entries pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Called just after a negedge: reset takes effect at the next edge.
    task automatic pulse_reset();
        rst = 1'b1;
        exp_q.delete();
        beat_q.delete();
        m_uf = 1'b0;
        m_te = 1'b0;
        push_idle(3);
        @(negedge clk);
        #1;
        rst = 1'b0;
        wait_drain();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        pulse_reset();
    endtask

    // One frame started by a single-cycle en_i pulse, followed by idle cycles.
    task automatic one_frame(input logic [63:0] px, input logic [7:0] last_mask,
                             input int uf_slot, input int te_slot);
        en = 1'b1;
        push_frame(px, last_mask, uf_slot, te_slot, FRAME_LEN);
        @(negedge clk);
        #1;
        en = 1'b0;
        wait_drain();
        push_idle(3);
        wait_drain();
    endtask

    initial begin
        // Reset state: outputs low during and after reset.
        push_idle(4);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        wait_drain();

        // Clean single frame, tlast on the 4th and 8th beats.
        one_frame(64'h17161514_13121110, 8'h88, -1, -1);

        // Missing beat in slot 1 of line 0: zero pixel, sticky underflow.
        one_frame(64'h16151413_12110010, 8'h88, 1, -1);
        do_reset();

        // en_i held high: three back-to-back frames, then en_i drops mid-frame 3.
        en = 1'b1;
        push_frame(64'h27262524_23222120, 8'h88, -1, -1, FRAME_LEN);
        push_frame(64'h37363534_33323130, 8'h88, -1, -1, FRAME_LEN);
        push_frame(64'h47464544_43424140, 8'h88, -1, -1, FRAME_LEN);
        push_idle(3);
        repeat (40) begin
            @(negedge clk);
            #1;
        end
        en = 1'b0;
        wait_drain();

        // tlast on beat 3 instead of beat 4: timing unchanged, flag per build.
        one_frame(64'h57565554_53525150, 8'h84, -1, 2);
        do_reset();

        // Reset during the second hsync cycle of line 0, then a full restart.
        en = 1'b1;
        push_frame(64'h67666564_63626160, 8'h88, -1, -1, 8);
        @(negedge clk);
        #1;
        en = 1'b0;
        repeat (7) begin
            @(negedge clk);
            #1;
        end
        pulse_reset();
        one_frame(64'h77767574_73727170, 8'h88, -1, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout got no completion, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
